// File: rtl/jqpart2_argmin.sv
// Second winner-take-all stage: reduces 64 group winners to the global minimum-cost
// disparity through a registered 4:1 tree (64->16->4->1), with line position tracking.
module jqpart2_argmin #(
  parameter int IMG_W  = 640,
  parameter int COST_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     en_in,
  input  logic [64*(COST_W+2)-1:0] cost_in,
  output logic [7:0]               disp_out,
  output logic [COST_W-1:0]        cost_out,
  output logic                     valid_out,
  output logic [9:0]               col_out,
  output logic                     eol
);

  localparam int unsigned EW       = COST_W + 2;
  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 1);

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [7:0]        disp;
  } cand_t;

  // Callers pass candidates in ascending disparity order, so strict less-than
  // leaves the lower disparity in place on equal cost.
  function automatic cand_t min4(input cand_t c0, input cand_t c1,
                                 input cand_t c2, input cand_t c3);
    cand_t best;
    best = c0;
    if (c1.cost < best.cost) best = c1;
    if (c2.cost < best.cost) best = c2;
    if (c3.cost < best.cost) best = c3;
    return best;
  endfunction

  cand_t w_ent [64];
  cand_t w_s1  [16];
  cand_t w_s2  [4];
  cand_t w_s3;

  cand_t r_s1  [16];
  cand_t r_s2  [4];
  logic [7:0]        r_disp;
  logic [COST_W-1:0] r_cost;
  logic              r_v1, r_v2, r_v3;
  logic [9:0]        r_col, r_col_nxt;
  logic              r_eol;

  always_comb begin
    for (int unsigned g = 0; g < 64; g++) begin
      w_ent[g].cost = cost_in[g*EW+2 +: COST_W];
      w_ent[g].disp = {6'(g), cost_in[g*EW +: 2]};
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 16; k++)
      w_s1[k] = min4(w_ent[4*k], w_ent[4*k+1], w_ent[4*k+2], w_ent[4*k+3]);
  end

  always_comb begin
    for (int unsigned m = 0; m < 4; m++)
      w_s2[m] = min4(r_s1[4*m], r_s1[4*m+1], r_s1[4*m+2], r_s1[4*m+3]);
  end

  assign w_s3 = min4(r_s2[0], r_s2[1], r_s2[2], r_s2[3]);

  // r_col_nxt is the column the next emerging valid pixel will take; r_col is
  // only updated when a valid pixel actually loads into the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 16; k++) r_s1[k] <= '0;
      for (int unsigned m = 0; m < 4; m++)  r_s2[m] <= '0;
      r_disp    <= '0;
      r_cost    <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_col     <= '0;
      r_col_nxt <= '0;
      r_eol     <= 1'b0;
    end else if (clken) begin
      r_s1   <= w_s1;
      r_s2   <= w_s2;
      r_disp <= w_s3.disp;
      r_cost <= w_s3.cost;
      r_v1   <= en_in;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_eol  <= r_v2 && (r_col_nxt == LAST_COL);
      if (r_v2) begin
        r_col     <= r_col_nxt;
        r_col_nxt <= (r_col_nxt == LAST_COL) ? '0 : r_col_nxt + 10'd1;
      end
    end
  end

  assign disp_out  = r_disp;
  assign cost_out  = r_cost;
  assign valid_out = r_v3;
  assign col_out   = r_col;
  assign eol       = r_eol;

endmodule

// File: tb/tb_jqpart2_argmin.sv
// Bench for jqpart2_argmin: directed and random pixels checked against a history-based
// reference (argmin over 256 disparities, output = input from 3 clken cycles earlier).
module tb_jqpart2_argmin;

  logic         clk = 1'b0;
  logic         rst, clken, en_in;
  logic [575:0] cost_in;

  logic [7:0] a_disp, b_disp;
  logic [6:0] a_cost, b_cost;
  logic       a_valid, b_valid, a_eol, b_eol;
  logic [9:0] a_col, b_col;

  jqpart2_argmin #(.IMG_W(4), .COST_W(7)) u_dut4 (
    .clk(clk), .rst(rst), .clken(clken), .en_in(en_in), .cost_in(cost_in),
    .disp_out(a_disp), .cost_out(a_cost), .valid_out(a_valid),
    .col_out(a_col), .eol(a_eol)
  );

  jqpart2_argmin #(.IMG_W(640), .COST_W(7)) u_dut640 (
    .clk(clk), .rst(rst), .clken(clken), .en_in(en_in), .cost_in(cost_in),
    .disp_out(b_disp), .cost_out(b_cost), .valid_out(b_valid),
    .col_out(b_col), .eol(b_eol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [575:0] vec;

  // Reference history indexed by clken-cycle count.
  int hd [1024];
  int hc [1024];
  int he [1024];
  int k = 0, base = 0, cnt = 0;
  int e_disp = 0, e_cost = 0, e_valid = 0;
  int e_col4 = 0, e_eol4 = 0, e_col640 = 0, e_eol640 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_min(input logic [575:0] v, output int d, output int c);
    c = 1 << 30;
    d = 0;
    for (int g = 0; g < 64; g++) begin
      int cc, dd;
      cc = int'(v[g*9+2 +: 7]);
      dd = 4*g + int'(v[g*9 +: 2]);
      if (cc < c || (cc == c && dd < d)) begin
        c = cc;
        d = dd;
      end
    end
  endfunction

  task automatic fill(input int c, input int l);
    for (int g = 0; g < 64; g++) vec[g*9 +: 9] = {7'(c), 2'(l)};
  endtask

  task automatic put(input int g, input int c, input int l);
    vec[g*9 +: 9] = {7'(c), 2'(l)};
  endtask

  task automatic rand_vec(input bit narrow);
    for (int g = 0; g < 64; g++)
      vec[g*9 +: 9] = {7'(narrow ? $urandom_range(0, 12) : $urandom_range(0, 127)),
                       2'($urandom_range(0, 3))};
  endtask

  task automatic step(input logic r, input logic ce, input logic en);
    int d, c;
    @(negedge clk);
    rst = r; clken = ce; en_in = en; cost_in = vec;
    @(posedge clk);
    #1;
    if (r) begin
      base = k; cnt = 0;
      e_col4 = 0; e_eol4 = 0; e_col640 = 0; e_eol640 = 0;
    end else if (ce) begin
      ref_min(vec, d, c);
      hd[k] = d; hc[k] = c; he[k] = int'(en);
      k++;
    end
    if (k >= base + 3) begin
      e_disp = hd[k-3]; e_cost = hc[k-3]; e_valid = he[k-3];
    end else begin
      e_disp = 0; e_cost = 0; e_valid = 0;
    end
    if (!r && ce) begin
      if (e_valid != 0) begin
        e_col4 = cnt % 4; e_col640 = cnt % 640; cnt++;
      end
      e_eol4   = (e_valid != 0 && e_col4 == 3) ? 1 : 0;
      e_eol640 = (e_valid != 0 && e_col640 == 639) ? 1 : 0;
    end
    chk("valid", a_valid, e_valid);
    chk("disp", a_disp, e_disp);
    chk("cost", a_cost, e_cost);
    chk("col4", a_col, e_col4);
    chk("eol4", a_eol, e_eol4);
    chk("valid640", b_valid, e_valid);
    chk("col640", b_col, e_col640);
    chk("eol640", b_eol, e_eol640);
  endtask

  task automatic isolated(input string tag, input int xd, input int xc);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk({tag, "_valid"}, a_valid, 1);
    chk({tag, "_disp"}, a_disp, xd);
    chk({tag, "_cost"}, a_cost, xc);
  endtask

  initial begin
    int ce_pat [12] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1};
    int pix;
    logic [7:0] held_d;

    rst = 1'b1; clken = 1'b0; en_in = 1'b0; cost_in = '0;
    vec = '0;
    step(1, 1, 0);
    step(1, 0, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_disp", a_disp, 0);
    chk("rst_cost", a_cost, 0);
    chk("rst_col", a_col, 0);
    chk("rst_eol", a_eol, 0);

    fill(31, 0); put(37, 3, 2);
    isolated("single_min", 150, 3);

    fill(10, 0); put(5, 2, 1); put(60, 2, 0);
    isolated("tie_lowdisp", 21, 2);

    fill(4, 3);
    isolated("all_equal", 3, 4);

    fill(127, 0); put(63, 0, 3);
    isolated("max_disp", 255, 0);

    fill(127, 0);
    isolated("all_max", 0, 127);

    // Stream with clken toggling; data changes only when it is sampled.
    pix = 0;
    for (int i = 0; i < 12; i++) begin
      if (ce_pat[i] != 0) rand_vec(1'b1);
      step(0, ce_pat[i] != 0, pix < 5);
      if (ce_pat[i] != 0) pix++;
    end

    // Hold with clken low: outputs must not move.
    held_d = a_disp;
    rand_vec(1'b0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("hold_disp", a_disp, held_d);

    // Single bubble inside a back-to-back stream.
    for (int i = 0; i < 6; i++) begin
      rand_vec(1'b1);
      step(0, 1, i != 2);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0);

    // Line wrap: 9 back-to-back valid pixels on the 4-wide instance.
    step(1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      rand_vec(1'b0);
      step(0, 1, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("wrap_last_col", a_col, 0);

    // Two pixels in flight, then reset before they emerge.
    rand_vec(1'b1); step(0, 1, 1);
    rand_vec(1'b1); step(0, 1, 1);
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("midrst_valid", a_valid, 0);
    rand_vec(1'b1); step(0, 1, 1);
    step(0, 1, 0); step(0, 1, 0);
    chk("midrst_next_valid", a_valid, 1);
    chk("midrst_next_col", a_col, 0);

    // Reset while clken is low still clears in-flight state.
    rand_vec(1'b1); step(0, 1, 1);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // Random mix of stalls, bubbles, ties and occasional resets.
    for (int i = 0; i < 300; i++) begin
      rand_vec($urandom_range(0, 1) == 1);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
